// File: rtl/seg7_scan_driver.sv
// Common-anode multiplexed 7-segment driver with leading-zero blanking, minus sign and guard time.
// New values are double-buffered and take effect only at frame boundaries.
module seg7_scan_driver #(
  parameter int NDIGITS     = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  input  logic                   neg,
  input  logic [NDIGITS-1:0]     dp_mask,
  output logic [NDIGITS-1:0]     an,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic                   frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NDIGITS);

  logic [PW-1:0]        presc_q, presc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [4*NDIGITS-1:0] disp_bcd_q, disp_bcd_d, pend_bcd_q, pend_bcd_d;
  logic                 disp_neg_q, disp_neg_d, pend_neg_q, pend_neg_d;
  logic [NDIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [NDIGITS-1:0]   an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic                 frame_done_q;
  logic                 slot_end, boundary;
  logic [3:0]           nib;
  logic                 dp_bit;
  logic [6:0]           seg_lit;
  int                   top;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  always_comb begin
    presc_d  = presc_q;
    idx_d    = idx_q;
    slot_end = (presc_q == PW'(REFRESH_DIV - 1));
    boundary = enable && slot_end && (idx_q == IW'(NDIGITS - 1));
    if (enable) begin
      if (slot_end) begin
        presc_d = '0;
        idx_d   = (idx_q == IW'(NDIGITS - 1)) ? '0 : idx_q + IW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // A load coinciding with the boundary bypasses the pending buffer entirely.
  always_comb begin
    disp_bcd_d = disp_bcd_q;
    disp_neg_d = disp_neg_q;
    disp_dp_d  = disp_dp_q;
    pend_bcd_d = pend_bcd_q;
    pend_neg_d = pend_neg_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    if (load && boundary) begin
      disp_bcd_d = bcd_in;
      disp_neg_d = neg;
      disp_dp_d  = dp_mask;
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_bcd_d = bcd_in;
      pend_neg_d = neg;
      pend_dp_d  = dp_mask;
      pend_vld_d = 1'b1;
    end else if (boundary && pend_vld_q) begin
      disp_bcd_d = pend_bcd_q;
      disp_neg_d = pend_neg_q;
      disp_dp_d  = pend_dp_q;
      pend_vld_d = 1'b0;
    end
  end

  // top = most significant nonzero digit (0 when the value is zero).
  always_comb begin
    nib    = '0;
    dp_bit = 1'b0;
    top    = 0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (disp_bcd_q[4*i +: 4] != 4'd0) top = i;
      if (idx_q == IW'(i)) begin
        nib    = disp_bcd_q[4*i +: 4];
        dp_bit = disp_dp_q[i];
      end
    end
    if (int'(idx_q) <= top)                              seg_lit = glyph(nib);
    else if (disp_neg_q && (int'(idx_q) == top + 1))     seg_lit = 7'h3F;
    else                                                 seg_lit = 7'h7F;
  end

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (enable && (presc_q >= PW'(GUARD))) begin
      an_d  = ~(NDIGITS'(1) << idx_q);
      seg_d = seg_lit;
      dp_d  = ~dp_bit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      disp_bcd_q   <= '0;
      disp_neg_q   <= 1'b0;
      disp_dp_q    <= '0;
      pend_bcd_q   <= '0;
      pend_neg_q   <= 1'b0;
      pend_dp_q    <= '0;
      pend_vld_q   <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_neg_q   <= disp_neg_d;
      disp_dp_q    <= disp_dp_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_neg_q   <= pend_neg_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= boundary;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a time-based display model queues the expected
// {an,seg,dp,frame_done} for every cycle; a monitor pops and compares each cycle.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int GRD   = 2;
  localparam int FRAME = N * DIV;
  localparam logic [12:0] DARK = {4'hF, 7'h7F, 1'b1, 1'b0};

  logic            clk = 1'b0;
  logic            reset, enable, load, neg;
  logic [4*N-1:0]  bcd_in;
  logic [N-1:0]    dp_mask;
  logic [N-1:0]    an;
  logic [6:0]      seg;
  logic            dp, frame_done;

  int checks = 0;
  int passes = 0;

  seg7_scan_driver #(.NDIGITS(N), .REFRESH_DIV(DIV), .GUARD(GRD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .bcd_in(bcd_in),
    .neg(neg), .dp_mask(dp_mask), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0]  glyph_tab [16];
  logic [12:0] exp_q [$];

  // Model state: enabled-cycle position within the frame, shown value and buffered value.
  int          m_t;
  logic [15:0] m_bcd, p_bcd;
  logic        m_neg, p_neg, m_pv;
  logic [3:0]  m_dp, p_dp;

  initial begin
    glyph_tab[0]  = 7'h40; glyph_tab[1]  = 7'h79; glyph_tab[2]  = 7'h24; glyph_tab[3]  = 7'h30;
    glyph_tab[4]  = 7'h19; glyph_tab[5]  = 7'h12; glyph_tab[6]  = 7'h02; glyph_tab[7]  = 7'h78;
    glyph_tab[8]  = 7'h00; glyph_tab[9]  = 7'h10; glyph_tab[10] = 7'h08; glyph_tab[11] = 7'h03;
    glyph_tab[12] = 7'h46; glyph_tab[13] = 7'h21; glyph_tab[14] = 7'h06; glyph_tab[15] = 7'h0E;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  function automatic logic [6:0] digit_glyph(input int slot);
    int top = 0;
    for (int i = 0; i < N; i++) if (m_bcd[4*i +: 4] != 4'd0) top = i;
    if (slot <= top)                 return glyph_tab[m_bcd[4*slot +: 4]];
    if (m_neg && slot == top + 1)    return 7'h3F;
    return 7'h7F;
  endfunction

  function automatic logic [12:0] model_out();
    int         presc, slot;
    logic [3:0] a;
    logic [6:0] s;
    logic       d;
    if (!enable) return DARK;
    presc = m_t % DIV;
    slot  = m_t / DIV;
    if (presc < GRD) begin
      a = 4'hF; s = 7'h7F; d = 1'b1;
    end else begin
      a = ~(4'b0001 << slot); s = digit_glyph(slot); d = ~m_dp[slot];
    end
    return {a, s, d, (m_t == FRAME - 1)};
  endfunction

  always @(posedge clk or negedge reset) begin
    logic bnd;
    if (!reset) begin
      exp_q.delete();
      exp_q.push_back(DARK);
      m_t = 0; m_bcd = '0; m_neg = 1'b0; m_dp = '0;
      p_bcd = '0; p_neg = 1'b0; p_dp = '0; m_pv = 1'b0;
    end else begin
      exp_q.push_back(model_out());
      bnd = enable && (m_t == FRAME - 1);
      if (enable) m_t = (m_t + 1) % FRAME;
      if (load && bnd) begin
        m_bcd = bcd_in; m_neg = neg; m_dp = dp_mask; m_pv = 1'b0;
      end else begin
        if (bnd && m_pv) begin
          m_bcd = p_bcd; m_neg = p_neg; m_dp = p_dp; m_pv = 1'b0;
        end
        if (load) begin
          p_bcd = bcd_in; p_neg = neg; p_dp = dp_mask; m_pv = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) chk("scan_out", {19'd0, an, seg, dp, frame_done}, {19'd0, exp_q.pop_front()});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_t(input int target);
    int n = 0;
    while (m_t != target && n < 200) begin
      step(1);
      n++;
    end
    if (n >= 200) chk("wait_timeout", 32'(m_t), 32'(target));
  endtask

  task automatic do_load(input logic [15:0] b, input logic ng, input logic [3:0] dm);
    bcd_in = b; neg = ng; dp_mask = dm; load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    logic [15:0] rb;
    reset = 1'b0; enable = 1'b0; load = 1'b0; bcd_in = '0; neg = 1'b0; dp_mask = '0;
    step(3);
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_dp", 32'(dp), 32'h1);
    chk("reset_frame_done", 32'(frame_done), 32'h0);

    reset = 1'b1; enable = 1'b1;
    step(70);

    wait_t(13);
    do_load(16'h0255, 1'b0, 4'b0000);
    step(70);

    do_load(16'h0025, 1'b1, 4'b0010);
    step(70);
    do_load(16'h1234, 1'b1, 4'b1000);
    step(70);

    wait_t(5);
    do_load(16'h0777, 1'b0, 4'b0000);
    wait_t(FRAME - 1);
    do_load(16'h0009, 1'b0, 4'b0001);
    step(70);

    wait_t(11);
    enable = 1'b0;
    step(20);
    enable = 1'b1;
    step(45);

    wait_t(18);
    do_load(16'h0888, 1'b1, 4'b1111);
    wait_t(2 * DIV + 5);
    reset = 1'b0;
    #1;
    chk("async_reset_an", 32'(an), 32'hF);
    chk("async_reset_seg", 32'(seg), 32'h7F);
    chk("async_reset_dp", 32'(dp), 32'h1);
    step(3);
    reset = 1'b1;
    step(80);

    for (int k = 0; k < 40; k++) begin
      step($urandom_range(1, 40));
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        step($urandom_range(1, 8));
        if ($urandom_range(0, 1) == 1) begin
          rb = 16'($urandom);
          do_load(rb, (rb != 0) ? 1'($urandom_range(0, 1)) : 1'b0, 4'($urandom));
        end
        step($urandom_range(1, 8));
        enable = 1'b1;
      end else begin
        rb = 16'($urandom);
        if ($urandom_range(0, 1) == 1) rb = rb & 16'h00FF;
        do_load(rb, (rb != 0) ? 1'($urandom_range(0, 1)) : 1'b0, 4'($urandom));
      end
    end
    step(80);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream consumer of the bin2bcdN output in the accelerometer display path. It takes a packed BCD value plus a sign flag and drives a common-anode, time-multiplexed 7-segment display. It provides a refresh prescaler, digit scan, leading-zero blanking, minus-sign placement and anti-ghosting guard time. New values are double-buffered and applied only at frame boundaries so a frame never shows a mix of old and new digits.

Parameters:
NDIGITS, 4, number of display digits (>=2)
REFRESH_DIV, 100000, clocks per digit slot (>= GUARD+2)
GUARD, 2, clocks at the start of each slot with all anodes off

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
enable  in  1  1 = scan runs; 0 = prescaler frozen, display dark
load  in  1  single-cycle strobe; captures bcd_in, neg, dp_mask
bcd_in  in  4*NDIGITS  packed BCD; nibble 0 = least significant digit
neg  in  1  value is negative; show minus sign
dp_mask  in  NDIGITS  decimal point per digit, 1 = lit
an  out  NDIGITS  anode selects, active-low
seg  out  7  {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
frame_done  out  1  one-cycle pulse when the last slot of a frame ends

Behaviour:
- Reset (reset=0, async): an=all 1, seg=7'h7F, dp=1, frame_done=0. Prescaler, digit index, display register, pending register and pending_valid all cleared.
- Prescaler counts 0..REFRESH_DIV-1 while enable=1 and wraps to 0. On wrap, the digit index advances 0..NDIGITS-1 and wraps to 0.
- Frame boundary is the cycle where prescaler=REFRESH_DIV-1, idx=NDIGITS-1 and enable=1. frame_done is 1 in the following cycle.
- load=1 captures {bcd_in,neg,dp_mask} into the pending register and sets pending_valid. A later load before the boundary overwrites the earlier one; last load wins.
- At a frame boundary with pending_valid=1: pending is copied to the display register and pending_valid is cleared.
- load in the same cycle as the boundary: bcd_in/neg/dp_mask go straight to the display register and pending_valid is cleared (bypass).
- enable=0: prescaler and idx hold, outputs dark (an=all 1, seg=7'h7F, dp=1), no frame_done. Loads are still captured and applied at the first boundary after re-enable.
- Outputs are registered, 1-cycle latency after (idx, prescaler).
- Guard: prescaler<GUARD gives an=all 1. Otherwise an has a 0 only at bit idx.
- Glyphs: 0-9 standard. Nibble values A-F produce hex glyphs and count as nonzero.
  - 0=7'h40, 2=7'h24, 5=7'h12, minus=7'h3F, blank=7'h7F.
- Leading-zero blanking: digits above the most significant nonzero digit are blank. Digit 0 is never blanked, so the value 0 shows "0".
- Minus: with neg=1, the blank digit immediately left of the most significant nonzero digit shows minus. If the top digit is nonzero there is no room, and the minus is dropped silently.
- dp follows dp_mask[idx] for the lit slot, including on blank digits. dp=1 during guard.
- Reset asserted mid-frame: immediate return to reset state; a pending value is lost.

Test Plan:
(Sim parameters: NDIGITS=4, REFRESH_DIV=8, GUARD=2.)
1. reset=0 then release, enable=1, no load -> an=4'b1110 only on slot 0 with seg=7'h40; slots 1-3 show an low but seg=7'h7F. frame_done pulses every 32 clocks.
2. load bcd_in=16'h0255, neg=0 mid-frame -> current frame still shows old value. Next frame: slot0 7'h12, slot1 7'h12, slot2 7'h24, slot3 7'h7F.
3. load 16'h0025, neg=1 -> slot2=7'h3F, slot3=7'h7F. Then load 16'h1234, neg=1 -> no minus shown, slot3=7'h79 ("1").
4. load asserted exactly on the boundary cycle with 16'h0009 -> next frame shows 9 on slot0, and no further update occurs at the following boundary.
5. enable=0 for 20 clocks mid-slot -> an=4'hF, seg=7'h7F, idx/prescaler frozen, no frame_done. On re-enable the scan resumes from the frozen count.
6. Assert reset at prescaler=5, slot 2, after a pending load -> outputs dark within the same cycle (async). After release, display shows 0; the pending value is discarded.
